// File: rtl/sprite_anim_mapper.sv
// Animated sprite compositor: hit test, ROM addressing and palette/background mux over a video scan.
// Latency ROM_LATENCY+2 cycles, one pixel per cycle; free-running, no backpressure.
module sprite_anim_mapper #(
  parameter int SPR_W           = 40,
  parameter int SPR_H           = 66,
  parameter int N_FRAMES        = 4,
  parameter int SCALE_LOG2      = 0,
  parameter int IDX_W           = 4,
  parameter int ROM_LATENCY     = 1,
  parameter int FRAME_DIV       = 6,
  parameter int TRANSPARENT_IDX = 0,
  parameter int ADDR_W          = $clog2(N_FRAMES * SPR_W * SPR_H),
  parameter int FRAME_W         = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               blank,
  input  logic               frame_start,
  input  logic [9:0]         pos_x,
  input  logic [9:0]         pos_y,
  input  logic               flip_x,
  input  logic               anim_en,
  input  logic               anim_oneshot,
  input  logic               anim_restart,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [IDX_W-1:0]   rom_q,
  output logic [IDX_W-1:0]   pal_index,
  input  logic [3:0]         pal_red,
  input  logic [3:0]         pal_green,
  input  logic [3:0]         pal_blue,
  input  logic [3:0]         bg_red,
  input  logic [3:0]         bg_green,
  input  logic [3:0]         bg_blue,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue,
  output logic [FRAME_W-1:0] cur_frame,
  output logic               anim_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  typedef struct packed {
    logic       hit;
    logic       blank;
    logic [3:0] bg_r;
    logic [3:0] bg_g;
    logic [3:0] bg_b;
  } pix_meta_t;

  localparam int                 FRAME_SZ  = SPR_W * SPR_H;
  localparam int                 CNT_W     = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [11:0]        SPAN_X    = 12'(SPR_W << SCALE_LOG2);
  localparam logic [11:0]        SPAN_Y    = 12'(SPR_H << SCALE_LOG2);
  localparam logic [11:0]        LAST_COL  = 12'(SPR_W - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(FRAME_DIV - 1);
  localparam logic [FRAME_W-1:0] FRAME_MAX = FRAME_W'(N_FRAMES - 1);
  localparam logic [IDX_W-1:0]   TRANSP    = IDX_W'(TRANSPARENT_IDX);

  logic [9:0]         px_q, px_d, py_q, py_d;
  logic               flip_q, flip_d, pos_vld_q, pos_vld_d;
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] cur_frame_q, cur_frame_d;
  logic               anim_done_q, anim_done_d;
  logic [ADDR_W-1:0]  rom_address_q, rom_address_d;
  logic [11:0]        rgb_q, rgb_d;
  pix_meta_t          meta_q [0:ROM_LATENCY];
  pix_meta_t          meta_d [0:ROM_LATENCY];

  logic [11:0] x_ext, y_ext, px_ext, py_ext, dx, dy, col, row, col_m;
  logic        hit;
  pix_meta_t   out_meta;

  assign x_ext  = {2'b00, DrawX};
  assign y_ext  = {2'b00, DrawY};
  assign px_ext = {2'b00, px_q};
  assign py_ext = {2'b00, py_q};

  // Placement is frozen for a whole video frame; pos_vld keeps a fresh reset from drawing at (0,0).
  always_comb begin
    px_d      = px_q;
    py_d      = py_q;
    flip_d    = flip_q;
    pos_vld_d = pos_vld_q;
    if (frame_start) begin
      px_d      = pos_x;
      py_d      = pos_y;
      flip_d    = flip_x;
      pos_vld_d = 1'b1;
    end
  end

  always_comb begin
    dx  = x_ext - px_ext;
    dy  = y_ext - py_ext;
    hit = pos_vld_q && (x_ext >= px_ext) && (x_ext < px_ext + SPAN_X)
                    && (y_ext >= py_ext) && (y_ext < py_ext + SPAN_Y);
    col   = dx >> SCALE_LOG2;
    row   = dy >> SCALE_LOG2;
    col_m = flip_q ? (LAST_COL - col) : col;
    rom_address_d = '0;
    if (hit) begin
      rom_address_d = ADDR_W'(cur_frame_q) * ADDR_W'(FRAME_SZ)
                    + ADDR_W'(row) * ADDR_W'(SPR_W) + ADDR_W'(col_m);
    end
  end

  // Stage 0 sits beside rom_address; the last stage lines up with rom_q.
  always_comb begin
    meta_d[0].hit   = hit;
    meta_d[0].blank = blank;
    meta_d[0].bg_r  = bg_red;
    meta_d[0].bg_g  = bg_green;
    meta_d[0].bg_b  = bg_blue;
    for (int i = 1; i <= ROM_LATENCY; i++) begin
      meta_d[i] = meta_q[i-1];
    end
  end

  always_comb begin
    out_meta = meta_q[ROM_LATENCY];
    rgb_d    = '0;
    if (out_meta.blank) begin
      if (out_meta.hit && (rom_q != TRANSP)) begin
        rgb_d = {pal_red, pal_green, pal_blue};
      end else begin
        rgb_d = {out_meta.bg_r, out_meta.bg_g, out_meta.bg_b};
      end
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (anim_restart) begin
      state_d = anim_en ? ST_RUN : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (anim_en) state_d = ST_RUN;
        ST_RUN: begin
          if (!anim_en) begin
            state_d = ST_IDLE;
          end else if (frame_start && (cnt_q == CNT_MAX) && (cur_frame_q == FRAME_MAX)
                       && anim_oneshot) begin
            state_d = ST_DONE;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    cur_frame_d = cur_frame_q;
    anim_done_d = anim_done_q;
    if (anim_restart) begin
      cnt_d       = '0;
      cur_frame_d = '0;
      anim_done_d = 1'b0;
    end else if ((state_q == ST_RUN) && anim_en && frame_start) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        if (cur_frame_q < FRAME_MAX) begin
          cur_frame_d = cur_frame_q + 1'b1;
        end else if (!anim_oneshot) begin
          cur_frame_d = '0;
        end else begin
          anim_done_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      px_q          <= '0;
      py_q          <= '0;
      flip_q        <= 1'b0;
      pos_vld_q     <= 1'b0;
      cnt_q         <= '0;
      cur_frame_q   <= '0;
      anim_done_q   <= 1'b0;
      rom_address_q <= '0;
      rgb_q         <= '0;
      for (int i = 0; i <= ROM_LATENCY; i++) begin
        meta_q[i] <= '0;
      end
    end else begin
      px_q          <= px_d;
      py_q          <= py_d;
      flip_q        <= flip_d;
      pos_vld_q     <= pos_vld_d;
      cnt_q         <= cnt_d;
      cur_frame_q   <= cur_frame_d;
      anim_done_q   <= anim_done_d;
      rom_address_q <= rom_address_d;
      rgb_q         <= rgb_d;
      for (int i = 0; i <= ROM_LATENCY; i++) begin
        meta_q[i] <= meta_d[i];
      end
    end
  end

  assign rom_address = rom_address_q;
  assign pal_index   = rom_q;
  assign red         = rgb_q[11:8];
  assign green       = rgb_q[7:4];
  assign blue        = rgb_q[3:0];
  assign cur_frame   = cur_frame_q;
  assign anim_done   = anim_done_q;

endmodule
